// File: rtl/vga_pkg.sv
// Shared video constants, colour type, motion FSM states and the
// bounce helper used by the box pixel stage.
package vga_pkg;

    localparam int RGB_W    = 4;
    localparam int H_START  = 144;
    localparam int V_START  = 35;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [3*RGB_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        MOVE_X,
        MOVE_Y
    } motion_state_e;

    typedef struct packed {
        logic       neg;
        logic [9:0] pos;
    } axis_t;

    // One axis step: clamp to the edge and flip direction on contact.
    function automatic axis_t bounce(
        input logic [9:0] pos,
        input logic       neg,
        input logic [9:0] maxPos,
        input logic [9:0] step
    );
        axis_t      r;
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        r   = '{neg: neg, pos: pos};
        if (!neg) begin
            if (sum >= {1'b0, maxPos}) r = '{neg: 1'b1, pos: maxPos};
            else                       r = '{neg: 1'b0, pos: sum[9:0]};
        end else begin
            if (pos <= step) r = '{neg: 1'b0, pos: 10'd0};
            else             r = '{neg: 1'b1, pos: pos - step};
        end
        return r;
    endfunction

endpackage

// File: rtl/box_motion.sv
// Per-frame diagonal motion of the square: one axis per cycle after
// a frame start, with edge clamp and bounce.
module box_motion
    import vga_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int V_ACT    = V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       frameStart,
    input  logic       pause,
    output logic [9:0] boxX,
    output logic [9:0] boxY
);

    localparam logic [9:0] XMAX  = 10'(H_ACT - BOX_SIZE);
    localparam logic [9:0] YMAX  = 10'(V_ACT - BOX_SIZE);
    localparam logic [9:0] STEPW = 10'(STEP);

    motion_state_e state_q, state_d;
    logic [9:0]    boxX_q, boxX_d, boxY_q, boxY_d;
    logic          dirX_q, dirX_d, dirY_q, dirY_d;
    axis_t         nx, ny;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            boxX_q  <= '0;
            boxY_q  <= '0;
            dirX_q  <= 1'b0;
            dirY_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            boxX_q  <= boxX_d;
            boxY_q  <= boxY_d;
            dirX_q  <= dirX_d;
            dirY_q  <= dirY_d;
        end
    end

    always_comb begin
        state_d = state_q;
        boxX_d  = boxX_q;
        boxY_d  = boxY_q;
        dirX_d  = dirX_q;
        dirY_d  = dirY_q;
        nx      = bounce(boxX_q, dirX_q, XMAX, STEPW);
        ny      = bounce(boxY_q, dirY_q, YMAX, STEPW);
        unique case (state_q)
            WAIT_FRAME: if (frameStart && !pause) state_d = MOVE_X;
            MOVE_X: begin
                boxX_d  = nx.pos;
                dirX_d  = nx.neg;
                state_d = MOVE_Y;
            end
            MOVE_Y: begin
                boxY_d  = ny.pos;
                dirY_d  = ny.neg;
                state_d = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    assign boxX = boxX_q;
    assign boxY = boxY_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline drawing a bouncing square; syncs and the
// frame tick travel alongside so colour and sync stay aligned.
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int   H_START_P = H_START,
    parameter int   V_START_P = V_START,
    parameter int   H_ACT     = H_ACTIVE,
    parameter int   V_ACT     = V_ACTIVE,
    parameter int   BOX_SIZE  = 32,
    parameter int   STEP      = 2,
    parameter rgb_t BOX_COLOR = 12'hF00,
    parameter rgb_t BG_COLOR  = 12'h00F
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       vActive,
    input  logic       hSync,
    input  logic       vSync,
    input  logic [9:0] hPixel,
    input  logic [9:0] vLine,
    input  logic       pause,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hSyncOut,
    output logic       vSyncOut,
    output logic       frameTick
);

    logic [9:0]  boxX, boxY;
    logic [9:0]  lx, ly;
    logic        inBox_d, fs_d;
    logic        inBox_q, va1_q, hs1_q, vs1_q, fs1_q;
    rgb_t        rgb_d, rgb_q;
    logic        hs2_q, vs2_q, tick_q;

    box_motion #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .BOX_SIZE(BOX_SIZE),
        .STEP    (STEP)
    ) u_motion (
        .clock     (clock),
        .rst       (rst),
        .frameStart(fs1_q),
        .pause     (pause),
        .boxX      (boxX),
        .boxY      (boxY)
    );

    // 11-bit compares keep box + size from wrapping near the far edge.
    always_comb begin
        lx      = hPixel - 10'(H_START_P);
        ly      = vLine - 10'(V_START_P);
        inBox_d = ({1'b0, lx} >= {1'b0, boxX})
               && ({1'b0, lx} <  {1'b0, boxX} + 11'(BOX_SIZE))
               && ({1'b0, ly} >= {1'b0, boxY})
               && ({1'b0, ly} <  {1'b0, boxY} + 11'(BOX_SIZE));
        fs_d    = (hPixel == 10'd0) && (vLine == 10'd0);
        rgb_d   = '0;
        if (va1_q) rgb_d = inBox_q ? BOX_COLOR : BG_COLOR;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            inBox_q <= 1'b0;
            va1_q   <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            fs1_q   <= 1'b0;
            rgb_q   <= '0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            inBox_q <= inBox_d;
            va1_q   <= vActive;
            hs1_q   <= hSync;
            vs1_q   <= vSync;
            fs1_q   <= fs_d;
            rgb_q   <= rgb_d;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            tick_q  <= fs1_q;
        end
    end

    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hSyncOut  = hs2_q;
    assign vSyncOut  = vs2_q;
    assign frameTick = tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer: vector table, streaming
// random pixels against a position model, and motion corner cases.
module tb_vga_box_renderer;

    logic       clock = 1'b0;
    logic       rst, vActive, hSync, vSync, pause;
    logic [9:0] hPixel, vLine;
    logic [3:0] red, green, blue;
    logic       hSyncOut, vSyncOut, frameTick;

    int total = 0;
    int bad   = 0;
    int mx, my, mdx, mdy;

    typedef struct {
        int h; int v; int va; int hs; int vs; int rgb;
    } vec_t;

    vga_box_renderer dut (
        .clock    (clock),
        .rst      (rst),
        .vActive  (vActive),
        .hSync    (hSync),
        .vSync    (vSync),
        .hPixel   (hPixel),
        .vLine    (vLine),
        .pause    (pause),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .hSyncOut (hSyncOut),
        .vSyncOut (vSyncOut),
        .frameTick(frameTick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int h, input int v, input int va,
                         input int hs, input int vs);
        hPixel  = 10'(h);
        vLine   = 10'(v);
        vActive = va[0];
        hSync   = hs[0];
        vSync   = vs[0];
    endtask

    function automatic int rgb_now();
        return int'({red, green, blue});
    endfunction

    function automatic int ref_rgb(input int h, input int v, input int va);
        int lx, ly;
        lx = (h - 144) & 1023;
        ly = (v - 35) & 1023;
        if (va == 0) return 0;
        if (lx >= mx && lx < mx + 32 && ly >= my && ly < my + 32)
            return 'hF00;
        return 'h00F;
    endfunction

    // Square travels diagonally, bouncing inside 608 x 448 of travel.
    task automatic adv_model();
        if (mdx > 0) begin
            if (mx + 2 >= 608) begin mx = 608; mdx = -1; end
            else mx += 2;
        end else begin
            if (mx <= 2) begin mx = 0; mdx = 1; end
            else mx -= 2;
        end
        if (mdy > 0) begin
            if (my + 2 >= 448) begin my = 448; mdy = -1; end
            else my += 2;
        end else begin
            if (my <= 2) begin my = 0; mdy = 1; end
            else my -= 2;
        end
    endtask

    task automatic chk_pos(input string nm);
        chk({nm, "_x"}, int'(dut.boxX), mx);
        chk({nm, "_y"}, int'(dut.boxY), my);
    endtask

    task automatic run_frame(input int p);
        pause = p[0];
        drive(0, 0, 0, 1, 1);
        tick1();
        chk("tick_early", int'(frameTick), 0);
        drive(5, 5, 0, 0, 0);
        tick1();
        chk("frameTick", int'(frameTick), 1);
        tick1();
        chk("tick_after", int'(frameTick), 0);
        tick1();
        tick1();
        if (p == 0) adv_model();
        chk_pos("frame_pos");
        pause = 1'b0;
    endtask

    task automatic stream_rand(input int n);
        int h, v, va, hs, vs;
        int pr, phs, pvs;
        pr = 0; phs = 0; pvs = 0;
        for (int k = 0; k <= n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end else begin
                h = 144 + mx + $urandom_range(0, 60) - 14;
                v = 35 + my + $urandom_range(0, 60) - 14;
            end
            if (h == 0 && v == 0) h = 1;
            va = $urandom_range(0, 4) != 0;
            hs = $urandom_range(0, 1);
            vs = $urandom_range(0, 1);
            drive(h, v, va, hs, vs);
            tick1();
            if (k > 0) begin
                chk("rand_rgb", rgb_now(), pr);
                chk("rand_hs", int'(hSyncOut), phs);
                chk("rand_vs", int'(vSyncOut), pvs);
            end
            pr  = ref_rgb(h, v, va);
            phs = hs;
            pvs = vs;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pause = 1'b0;
        drive(5, 5, 0, 0, 0);
        tick1();
        tick1();
        rst = 1'b0;
        mx = 0; my = 0; mdx = 1; mdy = 1;
    endtask

    initial begin
        vec_t tbl[8];
        int hp[4], vp[4];
        int guard;

        tbl[0] = '{144, 35, 1, 0, 0, 'hF00};
        tbl[1] = '{176, 35, 1, 1, 0, 'h00F};
        tbl[2] = '{175, 66, 1, 0, 1, 'hF00};
        tbl[3] = '{144, 67, 1, 1, 1, 'h00F};
        tbl[4] = '{143, 35, 1, 0, 0, 'h00F};
        tbl[5] = '{150, 40, 0, 1, 0, 'h000};
        tbl[6] = '{160, 50, 1, 0, 1, 'hF00};
        tbl[7] = '{600, 400, 1, 1, 1, 'h00F};

        do_reset();
        chk("rst_rgb", rgb_now(), 0);
        chk("rst_hs", int'(hSyncOut), 0);
        chk("rst_vs", int'(vSyncOut), 0);
        chk("rst_tick", int'(frameTick), 0);
        chk_pos("rst_pos");

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].h, tbl[i].v, tbl[i].va, tbl[i].hs, tbl[i].vs);
            tick1();
            tick1();
            chk("tbl_rgb", rgb_now(), tbl[i].rgb);
            chk("tbl_hs", int'(hSyncOut), tbl[i].hs);
            chk("tbl_vs", int'(vSyncOut), tbl[i].vs);
        end

        hp = '{1, 0, 0, 1};
        vp = '{0, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(150, 40, 0, hp[k], vp[k]);
            else       drive(150, 40, 0, 0, 0);
            tick1();
            if (k >= 1 && k <= 4) begin
                chk("seq_hs", int'(hSyncOut), hp[k-1]);
                chk("seq_vs", int'(vSyncOut), vp[k-1]);
            end
        end

        stream_rand(200);

        for (int f = 0; f < 3; f++) run_frame(0);
        chk("three_x", int'(dut.boxX), 6);
        chk("three_y", int'(dut.boxY), 6);

        guard = 0;
        while (!(mx == 606 && mdx > 0) && guard < 2000) begin
            run_frame(0);
            guard++;
        end
        chk("reach606_bound", int'(guard < 2000), 1);
        chk("pre_dirx", int'(dut.u_motion.dirX_q), 0);
        run_frame(0);
        chk("clamp_x", int'(dut.boxX), 608);
        chk("clamp_dirx", int'(dut.u_motion.dirX_q), 1);
        run_frame(0);
        chk("back_x", int'(dut.boxX), 606);

        guard = 0;
        while (!(my == 2 && mdy < 0) && guard < 2000) begin
            run_frame(0);
            guard++;
        end
        chk("reachy2_bound", int'(guard < 2000), 1);
        run_frame(0);
        chk("floor_y", int'(dut.boxY), 0);
        chk("floor_diry", int'(dut.u_motion.dirY_q), 0);

        for (int f = 0; f < 7; f++) run_frame(0);
        stream_rand(300);

        for (int f = 0; f < 5; f++) run_frame(1);

        pause = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick1();
        drive(5, 5, 0, 0, 0);
        tick1();
        pause = 1'b1;
        tick1();
        tick1();
        tick1();
        adv_model();
        chk_pos("pause_midmove");
        pause = 1'b0;

        do_reset();
        for (int f = 0; f < 50; f++) run_frame(0);
        chk("pre_rst_x", int'(dut.boxX), 100);
        chk("pre_rst_y", int'(dut.boxY), 100);
        drive(144 + 110, 35 + 110, 1, 1, 1);
        tick1();
        rst = 1'b1;
        drive(5, 5, 0, 0, 0);
        tick1();
        chk("mid_rst_rgb", rgb_now(), 0);
        chk("mid_rst_hs", int'(hSyncOut), 0);
        chk("mid_rst_vs", int'(vSyncOut), 0);
        chk("mid_rst_tick", int'(frameTick), 0);
        chk("mid_rst_x", int'(dut.boxX), 0);
        chk("mid_rst_y", int'(dut.boxY), 0);
        chk("mid_rst_dx", int'(dut.u_motion.dirX_q), 0);
        chk("mid_rst_dy", int'(dut.u_motion.dirY_q), 0);
        rst = 1'b0;
        tick1();
        chk("post_rst_rgb", rgb_now(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
- Pixel stage directly downstream of the video timing controller.
- Consumes the controller's vActive, hSync, vSync, hPixel and vLine, and draws a solid square on a solid background as 12-bit RGB (4/4/4).
- Moves the square diagonally once per frame and bounces it off the active-area edges.
- Delays the syncs by the same number of cycles as the colour path, so the VGA pins see aligned colour and sync.

Parameters:
H_START, 144, hPixel value of the first active column
V_START, 35, vLine value of the first active row
H_ACTIVE, 640, active width in pixels
V_ACTIVE, 480, active height in lines
BOX_SIZE, 32, square edge length in pixels
STEP, 2, pixels moved per axis per frame
BOX_COLOR, 12'hF00, square colour {r,g,b}
BG_COLOR, 12'h00F, background colour inside the active area

Ports:
clock  in  1  pixel clock, shared with the timing controller
rst  in  1  synchronous, active-high reset
vActive  in  1  active-video flag from the timing controller
hSync  in  1  horizontal sync from the timing controller
vSync  in  1  vertical sync from the timing controller
hPixel  in  10  horizontal count from the timing controller
vLine  in  10  vertical count from the timing controller
pause  in  1  1 = freeze square position
red  out  4  red channel
green  out  4  green channel
blue  out  4  blue channel
hSyncOut  out  1  hSync delayed 2 cycles
vSyncOut  out  1  vSync delayed 2 cycles
frameTick  out  1  one-cycle pulse per frame start

Behaviour:
- Clock and reset: one clock, `clock`. Reset `rst` is synchronous and active-high.
- Reset values:
  - red, green, blue, hSyncOut, vSyncOut and frameTick are 0.
  - boxX = 0, boxY = 0, dirX = +, dirY = +.
  - FSM is in WAIT_FRAME.
  - All pipeline registers are cleared.
- Reset mid-frame: takes effect on the next edge and discards all in-flight pixels.
- Pipeline stage 1 (registered):
  - lx = hPixel - H_START and ly = vLine - V_START, both 10-bit with wrap.
  - inBox = (lx >= boxX) && (lx < boxX + BOX_SIZE) && (ly >= boxY) && (ly < boxY + BOX_SIZE). The comparisons use 11-bit sums, so there is no overflow.
  - vActive, hSync and vSync are registered alongside.
  - frameStart = (hPixel == 0 && vLine == 0) is registered.
- Pipeline stage 2 (registered):
  - RGB = 12'h000 if vActive is 0, otherwise BOX_COLOR if inBox, otherwise BG_COLOR.
  - hSyncOut and vSyncOut register the stage-1 copies.
  - frameTick registers the stage-1 frameStart.
- Latency: 2 cycles from any input to its corresponding output. Sync polarity is passed through unchanged.
- Coordinate use:
  - lx and ly are meaningful only while vActive is 1.
  - Outside vActive the colour is black regardless of inBox.
- Position sampling: boxX and boxY are sampled in stage 1. A mid-frame update therefore cannot occur, because updates happen only in blanking (frame start is at vLine 0).
- Motion FSM, states WAIT_FRAME, MOVE_X, MOVE_Y:
  - WAIT_FRAME -> MOVE_X when stage-1 frameStart = 1 and pause = 0. Otherwise it stays in WAIT_FRAME.
  - MOVE_X, with XMAX = H_ACTIVE - BOX_SIZE:
    - dirX = + : if boxX + STEP >= XMAX then boxX = XMAX and dirX = -; else boxX += STEP.
    - dirX = - : if boxX <= STEP then boxX = 0 and dirX = +; else boxX -= STEP.
    - Then -> MOVE_Y.
  - MOVE_Y: same rule on boxY and dirY with YMAX = V_ACTIVE - BOX_SIZE. Then -> WAIT_FRAME.
- pause:
  - Sampled only in WAIT_FRAME. Asserting it during MOVE_X or MOVE_Y does not abort the update in progress.
  - frameTick still pulses while paused.
- Exact landing on an edge (boxX + STEP == XMAX): the square is clamped to the edge and the direction flips in the same update.

Decomposition:
- Shared package vga_pkg holds:
  - RGB width (4) and 12-bit colour type.
  - Default 640x480 active/offset constants (H_START, V_START, H_ACTIVE, V_ACTIVE).
  - FSM state encoding {WAIT_FRAME, MOVE_X, MOVE_Y}.
- One natural sub-module: box_motion. It contains the FSM, boxX/boxY/dirX/dirY and the clamp/bounce arithmetic, with outputs boxX and boxY.
- The pipeline and colour mux remain in vga_box_renderer.

Test Plan:
- Reset release, drive hPixel = 144 and vLine = 35 with vActive = 1 -> 2 cycles later RGB = F,0,0 (square at 0,0). With hPixel = 176 -> RGB = 0,0,F (lx = 32 is outside the square).
- Drive vActive = 0 with hPixel and vLine inside the square -> RGB = 0,0,0 after 2 cycles. Toggle hSync in a pattern 1,0,0,1 -> hSyncOut reproduces it exactly 2 cycles later; same for vSync.
- Present frame start (0,0) three times with pause = 0 -> boxX = boxY = 6 after the third update. frameTick pulses once per frame, 2 cycles after hPixel = vLine = 0.
- Preload by running frames until boxX = 606 with dirX = + -> next frame boxX = 608 (clamped) and dirX = -; following frame boxX = 606. At boxY = 2 with dirY = - -> boxY = 0 and dirY = +.
- pause = 1 over 5 frame starts -> position unchanged and 5 frameTick pulses. pause rising during MOVE_X -> both X and Y updates still complete.
- Assert rst mid-frame with the square at (100,100) -> next cycle all outputs are 0 and position returns to (0,0) with directions +/+.
